// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
// The pipeline side is the master. The unit is the slave.
interface alu_muldiv_if #(
   parameter int NB_DATA      = 32,
   parameter int NB_OPERATION = 6
);
   logic                    i_valid;
   logic [NB_OPERATION-1:0] i_op;
   logic [NB_DATA-1:0]      i_data_a;
   logic [NB_DATA-1:0]      i_data_b;
   logic                    o_ready;
   logic                    o_done;
   logic [NB_DATA-1:0]      o_result;
   logic [NB_DATA-1:0]      o_hi;
   logic [NB_DATA-1:0]      o_lo;

   modport master (
      output i_valid, i_op, i_data_a, i_data_b,
      input  o_ready, o_done, o_result, o_hi, o_lo
   );

   modport slave (
      input  i_valid, i_op, i_data_a, i_data_b,
      output o_ready, o_done, o_result, o_hi, o_lo
   );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, with one step per cycle
// over NB_DATA cycles. Signed operations work on magnitudes and fix up the signs when
// HI/LO are written. MFHI/MFLO/MTHI/MTLO complete in a single cycle.
module alu_muldiv #(
   parameter int NB_DATA      = 32,
   parameter int NB_OPERATION = 6
) (
   input logic         i_clock,
   input logic         i_reset,
   alu_muldiv_if.slave bus
);
   localparam int NB_CNT = $clog2(NB_DATA);
   localparam logic [NB_OPERATION-1:0] OP_MULT  = NB_OPERATION'(6'b011000);
   localparam logic [NB_OPERATION-1:0] OP_MULTU = NB_OPERATION'(6'b011001);
   localparam logic [NB_OPERATION-1:0] OP_DIV   = NB_OPERATION'(6'b011010);
   localparam logic [NB_OPERATION-1:0] OP_DIVU  = NB_OPERATION'(6'b011011);
   localparam logic [NB_OPERATION-1:0] OP_MFHI  = NB_OPERATION'(6'b010000);
   localparam logic [NB_OPERATION-1:0] OP_MTHI  = NB_OPERATION'(6'b010001);
   localparam logic [NB_OPERATION-1:0] OP_MFLO  = NB_OPERATION'(6'b010010);
   localparam logic [NB_OPERATION-1:0] OP_MTLO  = NB_OPERATION'(6'b010011);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state;
   logic [NB_CNT-1:0]      cnt;
   logic                   is_div;
   logic                   neg_lo;     // sign of the product or the quotient
   logic                   neg_hi;     // sign of the remainder (the dividend sign)
   logic                   div_zero;
   logic [NB_DATA-1:0]     operand;    // multiplicand or divisor magnitude
   logic [NB_DATA-1:0]     dividend_raw;
   logic [2*NB_DATA-1:0]   work;       // mul: {partial, multiplier}; div: {remainder, quotient}
   logic [NB_DATA-1:0]     hi;
   logic [NB_DATA-1:0]     lo;
   logic [NB_DATA-1:0]     result;
   logic                   ready;
   logic                   done;

   logic                   is_mul_op;
   logic                   is_div_op;
   logic                   is_signed_op;
   logic                   a_neg;
   logic                   b_neg;
   logic [NB_DATA-1:0]     a_mag;
   logic [NB_DATA-1:0]     b_mag;
   logic [NB_DATA:0]       mul_sum;
   logic [NB_DATA:0]       div_shift;
   logic [NB_DATA:0]       div_diff;
   logic                   div_ge;
   logic [2*NB_DATA-1:0]   step_next;
   logic [2*NB_DATA-1:0]   prod_signed;
   logic [NB_DATA-1:0]     quo;
   logic [NB_DATA-1:0]     rem;
   logic [NB_DATA-1:0]     fin_hi;
   logic [NB_DATA-1:0]     fin_lo;

   // Decode the incoming request and form the operand magnitudes used at acceptance.
   always_comb begin
      is_mul_op    = (bus.i_op == OP_MULT) || (bus.i_op == OP_MULTU);
      is_div_op    = (bus.i_op == OP_DIV)  || (bus.i_op == OP_DIVU);
      is_signed_op = (bus.i_op == OP_MULT) || (bus.i_op == OP_DIV);
      a_neg        = is_signed_op && bus.i_data_a[NB_DATA-1];
      b_neg        = is_signed_op && bus.i_data_b[NB_DATA-1];
      a_mag        = a_neg ? -bus.i_data_a : bus.i_data_a;
      b_mag        = b_neg ? -bus.i_data_b : bus.i_data_b;
   end

   // Compute one iteration step, plus the signed HI/LO values written after the last step.
   always_comb begin
      mul_sum   = {1'b0, work[2*NB_DATA-1:NB_DATA]} + (work[0] ? {1'b0, operand} : '0);
      div_shift = {work[2*NB_DATA-1:NB_DATA], work[NB_DATA-1]};
      div_diff  = div_shift - {1'b0, operand};
      div_ge    = (div_shift >= {1'b0, operand});
      if (is_div)
         step_next = {(div_ge ? div_diff[NB_DATA-1:0] : div_shift[NB_DATA-1:0]),
                      work[NB_DATA-2:0], div_ge};
      else
         step_next = {mul_sum, work[NB_DATA-1:1]};

      prod_signed = neg_lo ? -step_next : step_next;
      quo         = step_next[NB_DATA-1:0];
      rem         = step_next[2*NB_DATA-1:NB_DATA];
      if (!is_div) begin
         fin_hi = prod_signed[2*NB_DATA-1:NB_DATA];
         fin_lo = prod_signed[NB_DATA-1:0];
      end else if (div_zero) begin
         fin_hi = dividend_raw;
         fin_lo = '1;
      end else begin
         // The most-negative / -1 case produces a quotient magnitude of 2^(NB_DATA-1),
         // and the sign fix-up leaves it unchanged. So LO becomes the most-negative value and HI becomes 0.
         fin_hi = neg_hi ? -rem : rem;
         fin_lo = neg_lo ? -quo : quo;
      end
   end

   // Control FSM, operand latching, iteration state and the architectural registers.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state        <= IDLE;
         cnt          <= '0;
         is_div       <= 1'b0;
         neg_lo       <= 1'b0;
         neg_hi       <= 1'b0;
         div_zero     <= 1'b0;
         operand      <= '0;
         dividend_raw <= '0;
         work         <= '0;
         hi           <= '0;
         lo           <= '0;
         result       <= '0;
         ready        <= 1'b1;
         done         <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               ready <= 1'b1;
               done  <= 1'b0;
               if (bus.i_valid) begin
                  if (is_mul_op || is_div_op) begin
                     state        <= RUN;
                     ready        <= 1'b0;
                     cnt          <= NB_CNT'(NB_DATA - 1);
                     is_div       <= is_div_op;
                     operand      <= is_div_op ? b_mag : a_mag;
                     work         <= {{NB_DATA{1'b0}}, (is_div_op ? a_mag : b_mag)};
                     neg_lo       <= a_neg ^ b_neg;
                     neg_hi       <= a_neg;
                     div_zero     <= is_div_op && (bus.i_data_b == '0);
                     dividend_raw <= bus.i_data_a;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                     case (bus.i_op)
                        OP_MFHI: result <= hi;
                        OP_MFLO: result <= lo;
                        OP_MTHI: hi     <= bus.i_data_a;
                        OP_MTLO: lo     <= bus.i_data_a;
                        default: result <= '1;
                     endcase
                  end
               end
            end
            RUN: begin
               work <= step_next;
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  hi    <= fin_hi;
                  lo    <= fin_lo;
                  state <= DONE;
                  ready <= 1'b1;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_ready  = ready;
   assign bus.o_done   = done;
   assign bus.o_result = result;
   assign bus.o_hi     = hi;
   assign bus.o_lo     = lo;
endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv with NB_DATA=8.
// It runs directed cases followed by a random mix. The expected HI/LO/result values
// come from plain integer arithmetic applied to the MIPS HI/LO rules.
module tb_alu_muldiv;
   localparam int N = 8;
   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MFHI  = 6'b010000;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MFLO  = 6'b010010;
   localparam logic [5:0] OP_MTLO  = 6'b010011;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   logic [7:0] m_hi  = 8'h00;
   logic [7:0] m_lo  = 8'h00;
   logic [7:0] m_res = 8'h00;

   alu_muldiv_if #(.NB_DATA(N), .NB_OPERATION(6)) bus ();

   alu_muldiv #(.NB_DATA(N), .NB_OPERATION(6)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour. It uses integer arithmetic, where SV division truncates toward zero
   // and the remainder takes the sign of the dividend.
   task automatic model_apply(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
      int sa, sb, q, r;
      logic [31:0] pv;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (op)
         OP_MULT: begin
            pv = 32'(sa * sb);
            {m_hi, m_lo} = pv[15:0];
         end
         OP_MULTU: begin
            pv = {24'b0, a} * {24'b0, b};
            {m_hi, m_lo} = pv[15:0];
         end
         OP_DIV: begin
            if (b == 8'h00) begin
               m_hi = a; m_lo = 8'hFF;
            end else begin
               q = sa / sb; r = sa % sb;
               m_lo = q[7:0]; m_hi = r[7:0];
            end
         end
         OP_DIVU: begin
            if (b == 8'h00) begin
               m_hi = a; m_lo = 8'hFF;
            end else begin
               m_lo = a / b; m_hi = a % b;
            end
         end
         OP_MFHI: m_res = m_hi;
         OP_MFLO: m_res = m_lo;
         OP_MTHI: m_hi  = a;
         OP_MTLO: m_lo  = a;
         default: m_res = 8'hFF;
      endcase
   endtask

   // Present a request in the current (post-negedge) cycle, then move to the cycle after acceptance.
   task automatic issue(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
      bus.i_valid  = 1'b1;
      bus.i_op     = op;
      bus.i_data_a = a;
      bus.i_data_b = b;
      chk("ready_at_issue", 32'(bus.o_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Run a multiply or divide. When hold is set, keep i_valid high during RUN with a conflicting request.
   task automatic run_long(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b, input bit hold);
      bit busy_ok = 1'b1;
      issue(op, a, b);
      model_apply(op, a, b);
      if (hold) begin
         bus.i_op     = OP_MTHI;
         bus.i_data_a = 8'($urandom);
         bus.i_data_b = 8'($urandom);
      end else begin
         bus.i_valid = 1'b0;
      end
      for (int k = 1; k <= N; k++) begin
         if (bus.o_ready !== 1'b0 || bus.o_done !== 1'b0) busy_ok = 1'b0;
         @(negedge clk);
      end
      bus.i_valid = 1'b0;
      chk("busy_during_run", 32'(busy_ok), 32'd1);
      chk("done_after_run", 32'(bus.o_done), 32'd1);
      chk("ready_in_done", 32'(bus.o_ready), 32'd1);
      chk("hi_after_run", 32'(bus.o_hi), 32'(m_hi));
      chk("lo_after_run", 32'(bus.o_lo), 32'(m_lo));
      $display("op=%b a=%h b=%h hold=%0d -> hi=%h lo=%h", op, a, b, hold, bus.o_hi, bus.o_lo);
   endtask

   // Run a single-cycle operation and check its effect in the following cycle.
   task automatic single(input logic [5:0] op, input logic [7:0] a);
      issue(op, a, 8'($urandom));
      bus.i_valid = 1'b0;
      model_apply(op, a, 8'h00);
      chk("done_single", 32'(bus.o_done), 32'd1);
      chk("result_single", 32'(bus.o_result), 32'(m_res));
      chk("hi_single", 32'(bus.o_hi), 32'(m_hi));
      chk("lo_single", 32'(bus.o_lo), 32'(m_lo));
      $display("op=%b a=%h -> result=%h hi=%h lo=%h", op, a, bus.o_result, bus.o_hi, bus.o_lo);
   endtask

   initial begin
      logic [5:0] long_ops [4];
      logic [5:0] short_ops [6];
      bit done_seen;
      long_ops  = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
      short_ops = '{OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, 6'h3F, 6'h00};
      bus.i_valid  = 1'b0;
      bus.i_op     = '0;
      bus.i_data_a = '0;
      bus.i_data_b = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_ready", 32'(bus.o_ready), 32'd1);
      chk("reset_done", 32'(bus.o_done), 32'd0);
      chk("reset_result", 32'(bus.o_result), 32'd0);
      chk("reset_hi", 32'(bus.o_hi), 32'd0);
      chk("reset_lo", 32'(bus.o_lo), 32'd0);

      // Directed cases.
      run_long(OP_MULT, 8'hFD, 8'h05, 1'b0);
      chk("mult_neg_hi", 32'(bus.o_hi), 32'h0FF);
      chk("mult_neg_lo", 32'(bus.o_lo), 32'h0F1);
      @(negedge clk);
      run_long(OP_MULTU, 8'hFD, 8'h05, 1'b0);
      single(OP_MFHI, 8'h00);
      chk("mfhi_back_to_back", 32'(bus.o_result), 32'h004);
      @(negedge clk);
      run_long(OP_DIV, 8'hF9, 8'h02, 1'b0);
      chk("div_neg_lo", 32'(bus.o_lo), 32'h0FD);
      chk("div_neg_hi", 32'(bus.o_hi), 32'h0FF);
      run_long(OP_DIV, 8'h80, 8'hFF, 1'b0);
      chk("div_ovf_lo", 32'(bus.o_lo), 32'h080);
      chk("div_ovf_hi", 32'(bus.o_hi), 32'h000);
      run_long(OP_DIVU, 8'h07, 8'h00, 1'b0);
      chk("divz_hi", 32'(bus.o_hi), 32'h007);
      chk("divz_lo", 32'(bus.o_lo), 32'h0FF);
      run_long(OP_DIV, 8'h85, 8'h00, 1'b1);
      run_long(OP_MULTU, 8'hFF, 8'hFF, 1'b1);
      single(OP_MTLO, 8'h5A);
      single(OP_MFLO, 8'h00);
      chk("mflo_after_mtlo", 32'(bus.o_result), 32'h05A);
      single(6'h3F, 8'h00);
      chk("undef_result", 32'(bus.o_result), 32'h0FF);

      // Reset asserted during the fourth RUN cycle aborts the operation.
      @(negedge clk);
      issue(OP_MULT, 8'h7F, 8'h7F);
      bus.i_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_hi = 8'h00; m_lo = 8'h00; m_res = 8'h00;
      chk("abort_ready", 32'(bus.o_ready), 32'd1);
      chk("abort_hi", 32'(bus.o_hi), 32'd0);
      chk("abort_lo", 32'(bus.o_lo), 32'd0);
      done_seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (bus.o_done !== 1'b0) done_seen = 1'b1;
         @(negedge clk);
      end
      chk("abort_no_done", 32'(done_seen), 32'd0);
      $display("reset during RUN -> ready=%0d hi=%h lo=%h", bus.o_ready, bus.o_hi, bus.o_lo);

      // Random mix of long and single-cycle operations.
      for (int i = 0; i < 40; i++) begin
         logic [7:0] a, b;
         a = 8'($urandom);
         b = 8'($urandom);
         if ($urandom_range(0, 7) == 0) b = 8'h00;
         if ($urandom_range(0, 7) == 0) b = 8'hFF;
         if ($urandom_range(0, 7) == 0) a = 8'h80;
         if ($urandom_range(0, 9) < 6)
            run_long(long_ops[$urandom_range(0, 3)], a, b, 1'($urandom_range(0, 1)));
         else
            single(short_ops[$urandom_range(0, 5)], a);
         if ($urandom_range(0, 2) == 0) @(negedge clk);
      end
      single(OP_MFHI, 8'h00);
      single(OP_MFLO, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
